// File: rtl/box_metrics_pkg.sv
// ============================================================================
// Module   : box_metrics_pkg
// Brief    : Shared state encoding and width helpers for box_metrics_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package box_metrics_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int area_w(input int w);
        return 2 * w;
    endfunction

    function automatic int perim_w(input int w);
        return w + 2;
    endfunction

    function automatic int accum_w(input int w);
        return 2 * w + 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_shiftadd_mul.sv
// ============================================================================
// Module   : seq_shiftadd_mul
// Brief    : W x W unsigned shift-add multiplier, one multiplier bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_shiftadd_mul #(
    parameter int W  = 4,
    parameter int CW = $clog2(W) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             done,
    output logic [2*W-1:0]   product
);

    localparam int            AW     = 2 * W;
    localparam logic [CW-1:0] C_LAST = CW'(W - 1);

    logic [W-1:0]  a_q,   a_d;
    logic [W-1:0]  b_q,   b_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;

    logic [AW-1:0] w_partial;
    logic          w_bit;

    assign w_partial = {{W{1'b0}}, a_q} << cnt_q;
    // Top counter bit is only needed to hold the terminal value W.
    assign w_bit     = b_q[cnt_q[CW-2:0]];

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (start) begin
            a_d   = a;
            b_d   = b;
            acc_d = '0;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            if (w_bit) begin
                acc_d = acc_q + w_partial;
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == C_LAST) begin
                run_d = 1'b0;
            end
        end
    end

    // done marks the final step; product is the value the accumulator takes on it.
    assign done    = run_q && (cnt_q == C_LAST);
    assign product = acc_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/box_metrics_seq.sv
// ============================================================================
// Module   : box_metrics_seq
// Brief    : Handshaked box area/perimeter unit; optional running area sum
//            enabled by macro BOX_METRICS_ACCUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module box_metrics_seq
    import box_metrics_pkg::*;
#(
    parameter int W  = 4,
    parameter int CW = $clog2(W) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             x0,
    input  logic [W-1:0]             y0,
    input  logic [W-1:0]             x1,
    input  logic [W-1:0]             y1,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [area_w(W)-1:0]     area,
    output logic [perim_w(W)-1:0]    perim,
`ifdef BOX_METRICS_ACCUM_EN
    input  logic                     acc_clr,
    output logic [accum_w(W)-1:0]    area_sum,
`endif
    output logic                     busy
);

    localparam int AW = area_w(W);
    localparam int PW = perim_w(W);

    state_e        state_q, state_d;
    logic [AW-1:0] area_q,  area_d;
    logic [PW-1:0] perim_q, perim_d;

    logic [W-1:0]  w_dx;
    logic [W-1:0]  w_dy;
    logic          w_accept;
    logic          w_mul_done;
    logic [AW-1:0] w_mul_product;

    // Larger operand is always the minuend, so the difference never wraps.
    assign w_dx     = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
    assign w_dy     = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
    assign w_accept = (state_q == IDLE) && in_valid;

    seq_shiftadd_mul #(
        .W  (W),
        .CW (CW)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_accept),
        .a       (w_dx),
        .b       (w_dy),
        .done    (w_mul_done),
        .product (w_mul_product)
    );

    always_comb begin
        state_d = state_q;
        area_d  = area_q;
        perim_d = perim_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    perim_d = (PW'(w_dx) + PW'(w_dy)) << 1;
                    state_d = MUL;
                end
            end
            MUL: begin
                if (w_mul_done) begin
                    area_d  = w_mul_product;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            area_q  <= '0;
            perim_q <= '0;
        end else begin
            state_q <= state_d;
            area_q  <= area_d;
            perim_q <= perim_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == MUL) || (state_q == DONE);
    assign area      = area_q;
    assign perim     = perim_q;

`ifdef BOX_METRICS_ACCUM_EN
    localparam int SW = accum_w(W);

    logic [SW-1:0] area_sum_q, area_sum_d;

    // Clear wins over a same-edge handshake add.
    always_comb begin
        area_sum_d = area_sum_q;
        if (acc_clr) begin
            area_sum_d = '0;
        end else if ((state_q == DONE) && out_ready) begin
            area_sum_d = area_sum_q + SW'(area_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            area_sum_q <= '0;
        end else begin
            area_sum_q <= area_sum_d;
        end
    end

    assign area_sum = area_sum_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_box_metrics_seq.sv
// ============================================================================
// Module   : tb_box_metrics_seq
// Brief    : Directed self-checking bench for box_metrics_seq (W=4); the
//            area_sum checks build when BOX_METRICS_ACCUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_box_metrics_seq;

    localparam int W = 4;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   x0, y0, x1, y1;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] area;
    logic [W+1:0]   perim;
    logic           busy;
`ifdef BOX_METRICS_ACCUM_EN
    logic           acc_clr;
    logic [2*W+7:0] area_sum;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int lat;

    box_metrics_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x0        (x0),
        .y0        (y0),
        .x1        (x1),
        .y1        (y1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .area      (area),
        .perim     (perim),
`ifdef BOX_METRICS_ACCUM_EN
        .acc_clr   (acc_clr),
        .area_sum  (area_sum),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input logic [W-1:0] a, b, c, d);
        x0 = a; y0 = b; x1 = c; y1 = d;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    // Full operation with out_ready held high: accept, wait, check, handshake.
    task automatic run_op(input logic [W-1:0] a, b, c, d, input int ea, ep, input string tag);
        int n;
        chk({tag, "_in_ready_pre"}, in_ready, 1);
        set_ops(a, b, c, d);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_in_ready_mul"}, in_ready, 0);
        wait_valid(n);
        chk({tag, "_latency"}, n, 4);
        chk({tag, "_area"}, area, ea);
        chk({tag, "_perim"}, perim, ep);
        tick();
        chk({tag, "_valid_clr"}, out_valid, 0);
        chk({tag, "_in_ready_post"}, in_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_ops(0, 0, 0, 0);
`ifdef BOX_METRICS_ACCUM_EN
        acc_clr   = 1'b0;
`endif
        tick();
        tick();
        rst_n = 1'b1;

        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_area", area, 0);
        chk("rst_perim", perim, 0);
`ifdef BOX_METRICS_ACCUM_EN
        chk("rst_area_sum", area_sum, 0);
`endif

        run_op(1, 2, 5, 7, 20, 18, "basic");
        run_op(5, 7, 1, 2, 20, 18, "swapped");
        run_op(0, 0, 15, 15, 225, 60, "maxbox");
        run_op(3, 9, 3, 1, 0, 16, "zero_dx");

        // Backpressure: result held, no acceptance until after the handshake.
        out_ready = 1'b0;
        set_ops(2, 3, 6, 4);
        in_valid = 1'b1;
        tick();
        set_ops(0, 1, 3, 3);
        wait_valid(lat);
        chk("bp_latency", lat, 4);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid_hold", out_valid, 1);
            chk("bp_area_hold", area, 4);
            chk("bp_perim_hold", perim, 10);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_hs_valid", out_valid, 0);
        chk("bp_hs_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_second_accept", in_ready, 0);
        wait_valid(lat);
        chk("bp_second_latency", lat, 4);
        chk("bp_second_area", area, 6);
        chk("bp_second_perim", perim, 10);
        tick();

        // Operands changing during MUL with in_valid held high.
        set_ops(1, 1, 4, 3);
        in_valid = 1'b1;
        tick();
        set_ops(0, 0, 15, 15);
        tick();
        set_ops(7, 2, 9, 13);
        tick();
        set_ops(0, 0, 15, 15);
        wait_valid(lat);
        chk("hold_latency", lat, 2);
        chk("hold_area", area, 6);
        chk("hold_perim", perim, 10);
        tick();
        chk("hold_idle", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("hold_next_accept", busy, 1);
        wait_valid(lat);
        chk("hold_next_area", area, 225);
        chk("hold_next_perim", perim, 60);
        tick();

        // Reset asserted for one edge at multiplier step 2.
        set_ops(1, 2, 5, 7);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_area", area, 0);
        chk("mrst_perim", perim, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mrst_no_valid", out_valid, 0);
        end
        run_op(3, 1, 0, 5, 12, 14, "post_rst");

`ifdef BOX_METRICS_ACCUM_EN
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        chk("sum_clr", area_sum, 0);
        run_op(1, 2, 5, 7, 20, 18, "sum_a");
        chk("sum_after_a", area_sum, 20);
        run_op(0, 0, 15, 15, 225, 60, "sum_b");
        chk("sum_after_b", area_sum, 245);
        set_ops(1, 2, 5, 7);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        chk("sum_c_area", area, 20);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        chk("sum_clr_priority", area_sum, 0);
        chk("sum_c_hs", out_valid, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
